// File: rtl/mult_pkg.sv
// Shared types and helpers for the pipelined array multiplier.
package mult_pkg;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mult_mode_e;

  function automatic int cdiv(input int x, input int y);
    return (x + y - 1) / y;
  endfunction

endpackage

// File: rtl/mult_row_stage.sv
// One registered accumulation stage: adds up to R partial-product rows starting at FIRST_ROW.
module mult_row_stage #(
  parameter int N         = 8,
  parameter int R         = 2,
  parameter int FIRST_ROW = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_i,
  input  logic           vld_i,
  input  logic           neg_i,
  input  logic [2*N-1:0] sum_i,
  input  logic [N-1:0]   a_mag_i,
  input  logic [N-1:0]   b_rem_i,
  output logic           vld_o,
  output logic           neg_o,
  output logic [2*N-1:0] sum_o,
  output logic [N-1:0]   a_mag_o,
  output logic [N-1:0]   b_rem_o
);

  localparam int NR = ((N - FIRST_ROW) < R) ? (N - FIRST_ROW) : R;
  localparam int W  = 2 * N;

  logic [W-1:0] acc [NR+1];
  logic         vld_q, neg_q;
  logic [W-1:0] sum_q;
  logic [N-1:0] a_mag_q, b_rem_q;

  assign acc[0] = sum_i;

  // b_rem_i[0] always corresponds to global row FIRST_ROW; consumed bits are shifted out.
  for (genvar i = 0; i < NR; i++) begin : g_row
    logic [W-1:0] row;
    assign row = {{N{1'b0}}, a_mag_i & {N{b_rem_i[i]}}} << (FIRST_ROW + i);
    n_bit_adder #(.W(W)) u_add (
      .a_i  (acc[i]),
      .b_i  (row),
      .sum_o(acc[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      neg_q   <= 1'b0;
      sum_q   <= '0;
      a_mag_q <= '0;
      b_rem_q <= '0;
    end else if (en_i) begin
      vld_q   <= vld_i;
      neg_q   <= neg_i;
      sum_q   <= acc[NR];
      a_mag_q <= a_mag_i;
      b_rem_q <= b_rem_i >> NR;
    end
  end

  assign vld_o   = vld_q;
  assign neg_o   = neg_q;
  assign sum_o   = sum_q;
  assign a_mag_o = a_mag_q;
  assign b_rem_o = b_rem_q;

endmodule

// File: rtl/n_bit_adder.sv
// Plain W-bit adder used to accumulate partial-product rows; carry-out discarded.
module n_bit_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/pipe_array_mult.sv
// Pipelined signed/unsigned array multiplier, latency S+1, one result per cycle.
// The whole pipe freezes when the output is held; in_ready depends only on out_valid/out_ready.
module pipe_array_mult
  import mult_pkg::*;
#(
  parameter int N              = 8,
  parameter int ROWS_PER_STAGE = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int S = cdiv(N, ROWS_PER_STAGE);

  logic           adv;
  mult_mode_e     mode;
  logic [S:0]     vld_s, neg_s;
  logic [2*N-1:0] sum_s   [S+1];
  logic [N-1:0]   a_mag_s [S+1];
  logic [N-1:0]   b_rem_s [S+1];
  logic           out_valid_q;
  logic [2*N-1:0] p_q;
  logic           unused_tail;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign mode     = is_signed ? MODE_SIGNED : MODE_UNSIGNED;

  // The most negative value negates to itself, which is the correct unsigned magnitude.
  assign vld_s[0]   = in_valid;
  assign neg_s[0]   = (mode == MODE_SIGNED) && (a[N-1] ^ b[N-1]);
  assign sum_s[0]   = '0;
  assign a_mag_s[0] = ((mode == MODE_SIGNED) && a[N-1]) ? -a : a;
  assign b_rem_s[0] = ((mode == MODE_SIGNED) && b[N-1]) ? -b : b;

  for (genvar k = 1; k <= S; k++) begin : g_stage
    mult_row_stage #(
      .N        (N),
      .R        (ROWS_PER_STAGE),
      .FIRST_ROW((k - 1) * ROWS_PER_STAGE)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en_i   (adv),
      .vld_i  (vld_s[k-1]),
      .neg_i  (neg_s[k-1]),
      .sum_i  (sum_s[k-1]),
      .a_mag_i(a_mag_s[k-1]),
      .b_rem_i(b_rem_s[k-1]),
      .vld_o  (vld_s[k]),
      .neg_o  (neg_s[k]),
      .sum_o  (sum_s[k]),
      .a_mag_o(a_mag_s[k]),
      .b_rem_o(b_rem_s[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      p_q         <= '0;
    end else if (adv) begin
      out_valid_q <= vld_s[S];
      p_q         <= neg_s[S] ? -sum_s[S] : sum_s[S];
    end
  end

  assign out_valid   = out_valid_q;
  assign p           = p_q;
  assign busy        = out_valid_q || (|vld_s[S:1]);
  assign unused_tail = ^{a_mag_s[S], b_rem_s[S]};

endmodule

// File: tb/tb_pipe_array_mult.sv
// Scoreboard bench: default 8x8 instance plus two 5-bit instances (R=3 and R=N).
module tb_pipe_array_mult;

  localparam int N   = 8;
  localparam int S   = 4;
  localparam int LAT = S + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_ready, is_signed = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic         out_valid, out_ready = 1'b1, busy;
  logic [2*N-1:0] p;

  logic       iv5 = 1'b0, s5 = 1'b0;
  logic [4:0] a5 = '0, b5 = '0;
  logic       ir5a, ov5a, busy5a, ir5b, ov5b, busy5b;
  logic [9:0] p5a, p5b;
  logic       or5 = 1'b1;

  pipe_array_mult #(.N(N), .ROWS_PER_STAGE(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );
  pipe_array_mult #(.N(5), .ROWS_PER_STAGE(3)) u_n5r3 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5a), .a(a5), .b(b5),
    .is_signed(s5), .out_valid(ov5a), .out_ready(or5), .p(p5a), .busy(busy5a)
  );
  pipe_array_mult #(.N(5), .ROWS_PER_STAGE(5)) u_n5r5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5b), .a(a5), .b(b5),
    .is_signed(s5), .out_valid(ov5b), .out_ready(or5), .p(p5b), .busy(busy5b)
  );

  int     checks = 0, failures = 0;
  longint cyc = 0;
  int     rdy_mode = 0;
  bit     lat_chk = 1'b1;
  int     stall_cnt = 0;

  typedef struct {
    logic [63:0] p;
    longint      stamp;
    bit          lat;
  } exp_t;
  exp_t q8[$], q5a[$], q5b[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mref(input logic [63:0] x, input logic [63:0] y,
                                       input bit s, input int n);
    longint sx, sy;
    sx = longint'(x);
    sy = longint'(y);
    if (s && x[n-1]) sx = sx - (longint'(1) << n);
    if (s && y[n-1]) sy = sy - (longint'(1) << n);
    return 64'(sx * sy) & ((64'd1 << (2 * n)) - 64'd1);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                      input logic [63:0] e);
    bit acc;
    acc = 1'b0;
    a = x; b = y; is_signed = s; in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        q8.push_back('{e, cyc, lat_chk});
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic send_rand();
    logic [N-1:0] x, y;
    logic s;
    x = N'($urandom);
    y = N'($urandom);
    s = 1'($urandom_range(0, 1));
    send(x, y, s, mref(64'(x), 64'(y), s, N));
  endtask

  task automatic drain8();
    for (int i = 0; i < 500 && q8.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain8", 64'(q8.size()), 64'd0);
  endtask

  // Main-instance monitor: output compare, hold stability, stall ready.
  logic [2*N-1:0] prev_p;
  bit             prev_stall = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q8.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_p", 64'(p), 64'(prev_p));
      end
      prev_stall = out_valid && !out_ready;
      prev_p     = p;
      if (out_valid && !out_ready) begin
        stall_cnt++;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      if (out_valid && out_ready) begin
        if (q8.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
        else begin
          e = q8.pop_front();
          chk("p", 64'(p), e.p);
          if (e.lat) chk("latency", 64'(cyc - e.stamp), 64'(LAT));
        end
      end
    end
  end

  // 5-bit instances: always ready downstream, so every output is consumed on sight.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q5a.delete();
      q5b.delete();
    end else begin
      if (iv5 && ir5a) q5a.push_back('{mref(64'(a5), 64'(b5), s5, 5), cyc, 1'b1});
      if (iv5 && ir5b) q5b.push_back('{mref(64'(a5), 64'(b5), s5, 5), cyc, 1'b1});
      if (ov5a) begin
        if (q5a.size() == 0) chk("n5r3_spurious", 64'(ov5a), 64'd0);
        else begin
          e = q5a.pop_front();
          chk("n5r3_p", 64'(p5a), e.p);
          chk("n5r3_latency", 64'(cyc - e.stamp), 64'd3);
        end
      end
      if (ov5b) begin
        if (q5b.size() == 0) chk("n5r5_spurious", 64'(ov5b), 64'd0);
        else begin
          e = q5b.pop_front();
          chk("n5r5_p", 64'(p5b), e.p);
          chk("n5r5_latency", 64'(cyc - e.stamp), 64'd2);
        end
      end
    end
  end

  initial begin
    longint t0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_p", 64'(p), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed values with hand-computed products.
    send(8'hFF, 8'hFF, 1'b0, 64'hFE01);
    send(8'h80, 8'h7F, 1'b1, 64'hC080);
    send(8'h80, 8'h80, 1'b1, 64'h4000);
    send(8'h00, 8'h85, 1'b1, 64'h0000);
    send(8'h85, 8'h00, 1'b1, 64'h0000);
    send(8'h00, 8'hFF, 1'b0, 64'h0000);
    send(8'h7F, 8'h7F, 1'b1, 64'h3F01);
    send(8'hFF, 8'h01, 1'b1, 64'hFFFF);
    send(8'hFF, 8'h01, 1'b0, 64'h00FF);
    send(8'h03, 8'hFD, 1'b1, 64'hFFF7);
    drain8();

    // Back-to-back streaming: eight accepts must take exactly eight cycles.
    t0 = cyc;
    for (int i = 0; i < 8; i++) send_rand();
    chk("stream_cycles", 64'(cyc - t0), 64'd8);
    drain8();

    // Six-cycle backpressure window mid-stream.
    lat_chk = 1'b0;
    stall_cnt = 0;
    fork
      for (int i = 0; i < 12; i++) send_rand();
      begin
        repeat (4) @(posedge clk);
        rdy_mode = 1;
        repeat (6) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain8();
    chk("stall_seen", 64'(stall_cnt >= 3), 64'd1);

    // Reset with three transactions in flight.
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) send_rand();
    chk("busy_inflight", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_valid", 64'(out_valid), 64'd0);
    chk("no_stale_busy", 64'(busy), 64'd0);

    // Random mode/operands under random backpressure, 5-bit instances in parallel.
    lat_chk = 1'b0;
    rdy_mode = 2;
    fork
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end else send_rand();
      end
      begin
        for (int i = 0; i < 700; i++) begin
          a5  = 5'($urandom);
          b5  = 5'($urandom);
          s5  = 1'($urandom_range(0, 1));
          iv5 = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        iv5 = 1'b0;
      end
    join
    rdy_mode = 0;
    drain8();
    repeat (6) @(posedge clk);
    #1;
    chk("drain_n5r3", 64'(q5a.size()), 64'd0);
    chk("drain_n5r5", 64'(q5b.size()), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_busy_n5", 64'(busy5a | busy5b), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_array_mult.md
Name: pipe_array_mult

Overview:
- Pipelined, parametrised successor to the combinational array multiplier.
- Partial-product rows are accumulated across registered stages of ROWS_PER_STAGE rows each.
- Supports a per-transaction signed (two's-complement) or unsigned mode.
- Valid/ready handshake with full backpressure; sits between operand sources and the datapath result bus.

Parameters:
- N, 8, operand width in bits (N >= 2).
- ROWS_PER_STAGE, 2, partial-product rows accumulated per pipeline stage (1..N).
- S (localparam, derived), ceil(N/ROWS_PER_STAGE), number of accumulation stages. Total latency is S+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block accepts an input this cycle.
- a  in  N  multiplicand.
- b  in  N  multiplier.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  p is valid.
- out_ready  in  1  consumer accepts p.
- p  out  2N  product.
- busy  out  1  at least one stage holds a valid transaction.

Behaviour:
- Reset (async, active-high): all stage valid bits clear; out_valid=0; p=0; busy=0. in_ready=1 once rst deasserts. Reset mid-operation discards all in-flight transactions; no partial result is emitted.
- Advance condition: adv = !out_valid || out_ready.
  - in_ready = adv, purely combinational from out_valid/out_ready. No combinational path from in_valid to in_ready.
  - Input accepted at an edge where in_valid && in_ready.
  - When adv=0, every stage holds: data, valid and mode bits are frozen.
- Stage 0 (input conversion, part of accumulation stage 1):
  - If is_signed=1, take the magnitude of each operand (-2^(N-1) maps to magnitude 2^(N-1), which fits in N bits unsigned).
  - Record neg = is_signed & (a[N-1] ^ b[N-1]).
  - If is_signed=0, use operands as-is with neg=0.
- Accumulation stage k (1..S):
  - Adds rows (k-1)*R .. min(k*R, N)-1 of the unsigned array into a 2N-bit running sum, where row j = magnitude_a & {N{magnitude_b[j]}}, shifted left by j.
  - Carries magnitude_a, the remaining magnitude_b bits, neg and valid forward.
  - Final stage may hold fewer than R rows when R does not divide N.
- Output stage: p <= neg ? (~sum + 1) : sum, truncated to 2N bits; out_valid <= valid of stage S.
- Latency: with no stall, an input accepted at edge t gives out_valid=1 with its p after edge t+S+1 (default: 5 edges).
- Throughput: one transaction per cycle when out_ready=1.
- Ordering: strictly in order; no transaction is dropped or duplicated under any out_ready pattern.
- Output hold: while out_valid && !out_ready, p and out_valid hold stable.
- busy: OR of all stage valid bits plus out_valid.
- Boundary cases:
  - Zero operand gives p=0 in both modes; signed 0 times a negative gives 0, not 0 negated.
  - Both operands at the most negative value (signed) gives +2^(2N-2).
  - Stall on the cycle a stage becomes valid loses no data.
  - Simultaneous accept and output-consume in one cycle is allowed and is the normal streaming case.

Decomposition:
- Package mult_pkg:
  - constant function cdiv(x, y) for the stage count.
  - typedef mult_mode_e {MODE_UNSIGNED, MODE_SIGNED}.
  - parametrised stage payload struct: sum, a_mag, b_rem, neg, valid.
- Sub-module mult_row_stage (params N, R, FIRST_ROW): registered stage adding R partial-product rows, built from n_bit_adder instances, with a hold-enable input tied to adv.
- Top level: input conversion, generate loop of S mult_row_stage instances, output negation register, handshake logic.

Test Plan:
- Unsigned: a=0xFF, b=0xFF, is_signed=0, out_ready=1 -> after 5 edges out_valid=1, p=0xFE01.
- Signed: a=0x80, b=0x7F, is_signed=1 -> p=0xC080 (-16256). Then a=0x80, b=0x80 -> p=0x4000.
- Streaming: 8 back-to-back inputs with out_ready=1 -> 8 consecutive results in order, in_ready stays 1 throughout.
- Backpressure: hold out_ready=0 for 6 cycles mid-stream -> in_ready=0 while out_valid=1, p stable, no loss; all results correct after release.
- Reset mid-flight: assert rst with 3 transactions in flight -> out_valid and busy drop immediately; no stale result after release.
- Sweep N=5, ROWS_PER_STAGE=3 and ROWS_PER_STAGE=N: 10k random inputs in both modes vs reference model -> zero mismatches; latency S+1 checked each time.
